// File: rtl/egr_pkt_arb_pkg.sv
// rtl/egr_pkt_arb_pkg.sv - shared packet-format fields and PCC codes for the egress arbiter
package egr_pkt_arb_pkg;

  // Packet-format word: 32-bit payload with a 2-bit PCC field on top
  localparam int PFW_SZ  = 34;
  localparam int PCC_SZ  = 2;
  localparam int PRW_PCC = 32;

  typedef enum logic [1:0] {
    PCC_DATA   = 2'b00,
    PCC_SOP    = 2'b01,
    PCC_EOP    = 2'b10,
    PCC_BADEOP = 2'b11
  } pcc_t;

  function automatic pcc_t get_pcc(input logic [PFW_SZ-1:0] w);
    return pcc_t'(w[PRW_PCC +: PCC_SZ]);
  endfunction

  function automatic logic [PFW_SZ-1:0] set_pcc(input logic [PFW_SZ-1:0] w, input pcc_t p);
    logic [PFW_SZ-1:0] r;
    r = w;
    r[PRW_PCC +: PCC_SZ] = p;
    return r;
  endfunction

  // EOP and BADEOP both close a packet
  function automatic logic is_end(input pcc_t p);
    return (p == PCC_EOP) || (p == PCC_BADEOP);
  endfunction

endpackage

// File: rtl/egr_pkt_arb_rr_pick.sv
// rtl/egr_pkt_arb_rr_pick.sv - rotating-priority find-first over a request vector
module egr_pkt_arb_rr_pick #(
  parameter int num_ports = 4,
  parameter int ptr_w     = 2
) (
  input  logic [num_ports-1:0] req,
  input  logic [ptr_w-1:0]     start,
  output logic [num_ports-1:0] sel,
  output logic                 found
);

  // Walk from start upward with wrap; the first set request wins
  always_comb begin
    logic [ptr_w-1:0] idx;
    idx   = '0;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < num_ports; i++) begin
      idx = ptr_w'((int'(start) + i) % num_ports);
      if (!found && req[idx]) begin
        sel[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/egr_pkt_arb.sv
// rtl/egr_pkt_arb.sv - packet-granular round-robin arbiter with framing enforcement
module egr_pkt_arb
  import egr_pkt_arb_pkg::*;
#(
  parameter int num_ports = 4,
  parameter int max_len   = 1518,
  parameter int len_sz    = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [num_ports-1:0]        r_srdy,
  output logic [num_ports-1:0]        r_drdy,
  input  logic [num_ports*PFW_SZ-1:0] r_data,
  output logic                        p_srdy,
  input  logic                        p_drdy,
  output logic [PFW_SZ-1:0]           p_data,
  output logic [num_ports-1:0]        p_grant
);

  localparam int PTR_W = $clog2(num_ports);
  localparam logic [len_sz-1:0] LAST_BODY = len_sz'(max_len - 1);

  typedef enum logic [1:0] {s_idle, s_packet, s_flush} state_t;

  state_t                 state, nxt_state;
  logic [num_ports-1:0]   gnt, nxt_gnt;
  logic [PTR_W-1:0]       rr_ptr, nxt_rr_ptr;
  logic [len_sz-1:0]      wcnt, nxt_wcnt;

  logic [PFW_SZ-1:0]      port_word [num_ports];
  logic [num_ports-1:0]   sel_oh;
  logic                   sel_found;
  logic [PTR_W-1:0]       sel_idx, gnt_idx, ptr_after_gnt;
  logic [PFW_SZ-1:0]      sel_word, gnt_word;
  pcc_t                   sel_pcc, gnt_pcc;
  logic                   gnt_srdy;
  logic                   p_srdy_c;
  logic [num_ports-1:0]   drdy_c;

  egr_pkt_arb_rr_pick #(
    .num_ports (num_ports),
    .ptr_w     (PTR_W)
  ) u_rr_pick (
    .req   (r_srdy),
    .start (rr_ptr),
    .sel   (sel_oh),
    .found (sel_found)
  );

  // Slice the flat requester bus and encode the one-hot selects to indices
  always_comb begin
    sel_idx = '0;
    gnt_idx = '0;
    for (int i = 0; i < num_ports; i++) begin
      port_word[i] = r_data[i*PFW_SZ +: PFW_SZ];
      if (sel_oh[i]) sel_idx = PTR_W'(i);
      if (gnt[i])    gnt_idx = PTR_W'(i);
    end
  end

  assign sel_word      = port_word[sel_idx];
  assign gnt_word      = port_word[gnt_idx];
  assign sel_pcc       = get_pcc(sel_word);
  assign gnt_pcc       = get_pcc(gnt_word);
  assign gnt_srdy      = r_srdy[gnt_idx];
  assign ptr_after_gnt = PTR_W'((int'(gnt_idx) + 1) % num_ports);

  // Next-state and pass-through datapath; handshakes are combinational
  always_comb begin
    nxt_state  = state;
    nxt_gnt    = gnt;
    nxt_rr_ptr = rr_ptr;
    nxt_wcnt   = wcnt;
    p_srdy_c   = 1'b0;
    drdy_c     = '0;
    p_data     = gnt_word;
    case (state)
      s_idle: begin
        p_data = sel_word;
        if (sel_found) begin
          if (sel_pcc == PCC_SOP) begin
            p_srdy_c = 1'b1;
            drdy_c   = sel_oh & {num_ports{p_drdy}};
            if (p_drdy) begin
              nxt_state = s_packet;
              nxt_gnt   = sel_oh;
              nxt_wcnt  = len_sz'(1);
            end
          end else begin
            // Stray non-SOP word outside a packet is dropped
            drdy_c = sel_oh;
          end
        end
      end
      s_packet: begin
        if (gnt_srdy) begin
          p_srdy_c = 1'b1;
          if (is_end(gnt_pcc)) begin
            drdy_c = gnt & {num_ports{p_drdy}};
            if (p_drdy) begin
              nxt_state  = s_idle;
              nxt_gnt    = '0;
              nxt_rr_ptr = ptr_after_gnt;
            end
          end else if (gnt_pcc == PCC_SOP) begin
            // Close the open packet with BADEOP; the SOP itself stays pending
            p_data = set_pcc(gnt_word, PCC_BADEOP);
            if (p_drdy) begin
              nxt_state  = s_idle;
              nxt_gnt    = '0;
              nxt_rr_ptr = ptr_after_gnt;
            end
          end else if (wcnt == LAST_BODY) begin
            p_data = set_pcc(gnt_word, PCC_BADEOP);
            drdy_c = gnt & {num_ports{p_drdy}};
            if (p_drdy) nxt_state = s_flush;
          end else begin
            drdy_c = gnt & {num_ports{p_drdy}};
            if (p_drdy) nxt_wcnt = wcnt + len_sz'(1);
          end
        end
      end
      s_flush: begin
        if (gnt_srdy) begin
          if (gnt_pcc == PCC_SOP) begin
            nxt_state  = s_idle;
            nxt_gnt    = '0;
            nxt_rr_ptr = ptr_after_gnt;
          end else begin
            drdy_c = gnt;
            if (is_end(gnt_pcc)) begin
              nxt_state  = s_idle;
              nxt_gnt    = '0;
              nxt_rr_ptr = ptr_after_gnt;
            end
          end
        end
      end
      default: begin
        nxt_state = s_idle;
        nxt_gnt   = '0;
      end
    endcase
  end

  // Handshakes are held off for the whole reset pulse, not just at the edge
  assign r_drdy  = reset ? '0 : drdy_c;
  assign p_srdy  = reset ? 1'b0 : p_srdy_c;
  assign p_grant = gnt;

  // State, owner, round-robin pointer and word counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= s_idle;
      gnt    <= '0;
      rr_ptr <= '0;
      wcnt   <= '0;
    end else begin
      state  <= nxt_state;
      gnt    <= nxt_gnt;
      rr_ptr <= nxt_rr_ptr;
      wcnt   <= nxt_wcnt;
    end
  end

endmodule

// File: tb/tb_egr_pkt_arb.sv
// tb/tb_egr_pkt_arb.sv - randomized self-checking bench for egr_pkt_arb
module tb_egr_pkt_arb;
  import egr_pkt_arb_pkg::*;

  localparam int NP = 4;
  localparam int W  = PFW_SZ;
  localparam int ML = 4;

  typedef logic [W-1:0] word_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [NP-1:0]   r_srdy, r_drdy, p_grant;
  logic [NP*W-1:0] r_data;
  logic            p_srdy, p_drdy;
  logic [W-1:0]    p_data;

  always #5 clk = ~clk;

  egr_pkt_arb #(.num_ports(NP), .max_len(ML), .len_sz(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .r_srdy  (r_srdy),
    .r_drdy  (r_drdy),
    .r_data  (r_data),
    .p_srdy  (p_srdy),
    .p_drdy  (p_drdy),
    .p_data  (p_data),
    .p_grant (p_grant)
  );

  word_t         stage [NP][$];
  word_t         src_q [NP][$];
  word_t         exp_q [NP][$];
  word_t         eg_log[$];
  logic [NP-1:0] gnt_log[$];
  logic [NP-1:0] last_gnt = '0;
  int n_checks = 0, n_fail = 0;
  int srdy_pct = 100, drdy_mode = 0, tag = 0;
  bit chk_mirror = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic word_t mk(input pcc_t c, input int pay);
    word_t w;
    w = '0;
    w[31:0] = pay;
    return set_pcc(w, c);
  endfunction

  // Per-port framing rules: what the egress must show for one port's word stream
  function automatic void model_port(input int p);
    bit in_pkt = 0, flushing = 0, again;
    int len = 0;
    pcc_t c;
    foreach (stage[p][k]) begin
      c = get_pcc(stage[p][k]);
      again = 1;
      while (again) begin
        again = 0;
        if (flushing) begin
          if (c == PCC_SOP) begin flushing = 0; again = 1; end
          else if (c == PCC_EOP || c == PCC_BADEOP) flushing = 0;
        end else if (!in_pkt) begin
          if (c == PCC_SOP) begin exp_q[p].push_back(stage[p][k]); in_pkt = 1; len = 1; end
        end else if (c == PCC_EOP || c == PCC_BADEOP) begin
          exp_q[p].push_back(stage[p][k]); in_pkt = 0;
        end else if (c == PCC_SOP) begin
          exp_q[p].push_back(set_pcc(stage[p][k], PCC_BADEOP)); in_pkt = 0; again = 1;
        end else if (len + 1 == ML) begin
          exp_q[p].push_back(set_pcc(stage[p][k], PCC_BADEOP)); in_pkt = 0; flushing = 1;
        end else begin
          exp_q[p].push_back(stage[p][k]); len++;
        end
      end
    end
  endfunction

  task automatic add(input int p, input pcc_t c, input int pay);
    stage[p].push_back(mk(c, pay));
  endtask

  task automatic commit();
    for (int p = 0; p < NP; p++) begin
      model_port(p);
      foreach (stage[p][k]) src_q[p].push_back(stage[p][k]);
      stage[p].delete();
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NP; i++) n += src_q[i].size() + exp_q[i].size();
    return n;
  endfunction

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      r_srdy[i] = (src_q[i].size() > 0) && ($urandom_range(99) < srdy_pct);
      r_data[i*W +: W] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
    case (drdy_mode)
      0:       p_drdy = 1'b1;
      1:       p_drdy = ($urandom_range(99) < 70);
      default: p_drdy = ~p_drdy;
    endcase
  endtask

  task automatic observe();
    int port;
    logic [NP-1:0] src;
    check("drdy_onehot", 64'($countones(r_drdy) <= 1), 1);
    if (p_grant != 0) check("drdy_owner", r_drdy & ~p_grant, 0);
    if (chk_mirror && p_grant != 0) check("drdy_mirror", r_drdy, p_grant & {NP{p_drdy}});
    if (p_grant != 0 && p_grant != last_gnt) gnt_log.push_back(p_grant);
    last_gnt = p_grant;
    if (p_srdy && p_drdy) begin
      port = -1;
      src = (p_grant != 0) ? p_grant : r_drdy;
      for (int i = 0; i < NP; i++) if (src[i]) port = i;
      if (port < 0) check("egress_src", 0, 1);
      else if (exp_q[port].size() == 0) check("egress_extra", 0, 1);
      else check("egress_data", p_data, exp_q[port].pop_front());
      eg_log.push_back(p_data);
    end
    for (int i = 0; i < NP; i++)
      if (r_srdy[i] && r_drdy[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    observe();
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin cycle(); n++; end
    check(name, pending(), 0);
    cycle();
  endtask

  task automatic clear_logs();
    eg_log.delete();
    gnt_log.delete();
  endtask

  task automatic pkt(input int p, input int nbody);
    add(p, PCC_SOP, ++tag);
    for (int k = 0; k < nbody; k++) add(p, PCC_DATA, ++tag);
    add(p, PCC_EOP, ++tag);
  endtask

  initial begin
    reset = 1'b1; r_srdy = '0; r_data = '0; p_drdy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_r_drdy", r_drdy, 0);
    check("rst_p_srdy", p_srdy, 0);
    check("rst_p_grant", p_grant, 0);
    reset = 1'b0;
    #1;
    check("rst_rr_ptr", dut.rr_ptr, 0);

    // Two 3-word packets on ports 0 and 2
    clear_logs();
    pkt(0, 1); pkt(2, 1); commit();
    drain("t2_drain", 200);
    check("t2_ngnt", gnt_log.size(), 2);
    check("t2_gnt0", gnt_log[0], 4'b0001);
    check("t2_gnt1", gnt_log[1], 4'b0100);
    check("t2_words", eg_log.size(), 6);
    check("t2_rr_ptr", dut.rr_ptr, 3);

    // Round-robin fairness: port 0 with two packets against port 2
    clear_logs();
    pkt(0, 0); pkt(0, 1); pkt(2, 0); commit();
    drain("rr_drain", 200);
    check("rr_ngnt", gnt_log.size(), 3);
    check("rr_gnt0", gnt_log[0], 4'b0001);
    check("rr_gnt1", gnt_log[1], 4'b0100);
    check("rr_gnt2", gnt_log[2], 4'b0001);
    check("rr_ptr", dut.rr_ptr, 1);

    // Stray body word in idle is consumed without egress
    clear_logs();
    add(1, PCC_DATA, 'h55); commit();
    cycle();
    check("stray_p_srdy", p_srdy, 0);
    check("stray_r_drdy", r_drdy, 4'b0010);
    drain("stray_drain", 50);
    check("stray_words", eg_log.size(), 0);

    // Missing EOP: second SOP closes the packet with BADEOP and is re-arbitrated
    clear_logs();
    add(0, PCC_SOP, 'h200); add(0, PCC_DATA, 'h201); add(0, PCC_SOP, 'h202);
    add(0, PCC_DATA, 'h203); add(0, PCC_EOP, 'h204); commit();
    drain("nosop_drain", 200);
    check("nosop_words", eg_log.size(), 6);
    check("nosop_bad", eg_log[2], mk(PCC_BADEOP, 'h202));
    check("nosop_resop", eg_log[3], mk(PCC_SOP, 'h202));

    // Over-length packet on port 3: cut at max_len, remainder flushed
    clear_logs();
    add(3, PCC_SOP, 'h300);
    for (int k = 1; k <= 5; k++) add(3, PCC_DATA, 'h300 + k);
    add(3, PCC_EOP, 'h306); commit();
    drain("long_drain", 200);
    check("long_words", eg_log.size(), 4);
    check("long_bad", eg_log[3], mk(PCC_BADEOP, 'h303));
    check("long_idle", p_grant, 0);

    // Toggling p_drdy: exactly max_len words pass, ready mirrors p_drdy
    clear_logs();
    drdy_mode = 2; chk_mirror = 1;
    pkt(1, 2); commit();
    drain("tog_drain", 200);
    chk_mirror = 0;
    check("tog_words", eg_log.size(), 4);
    check("tog_eop", get_pcc(eg_log[3]), PCC_EOP);
    clear_logs();
    pkt(2, 4); commit();
    drain("tog6_drain", 200);
    check("tog6_words", eg_log.size(), 4);
    drdy_mode = 0;

    // Reset pulse in the middle of a packet
    pkt(0, 2); commit();
    cycle(); cycle();
    @(negedge clk);
    drive();
    #1;
    check("mid_pre_p_srdy", p_srdy, 1);
    #1 reset = 1'b1;
    #1;
    check("mid_r_drdy", r_drdy, 0);
    check("mid_p_srdy", p_srdy, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NP; i++) begin src_q[i].delete(); exp_q[i].delete(); end
    drive();
    #1;
    check("mid_grant", p_grant, 0);
    check("mid_rr_ptr", dut.rr_ptr, 0);

    // Randomized traffic with framing faults, random source and egress stalls
    drdy_mode = 1;
    for (int r = 0; r < 30; r++) begin
      srdy_pct = $urandom_range(50, 100);
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(3) == 0) continue;
        for (int k = 0; k < $urandom_range(1, 3); k++) begin
          int e;
          if ($urandom_range(9) != 0) add(p, PCC_SOP, ++tag);
          for (int b = 0; b < $urandom_range(0, 5); b++) add(p, PCC_DATA, ++tag);
          e = $urandom_range(9);
          if (e < 7) add(p, PCC_EOP, ++tag);
          else if (e == 7) add(p, PCC_BADEOP, ++tag);
        end
        add(p, PCC_EOP, ++tag);
      end
      commit();
      drain("rand_drain", 3000);
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
